// File: rtl/multicycle_adder_pkg.sv
// multicycle_adder_pkg
//   Shared types and elaboration helpers for the multi-cycle adder.
//   - state_e   : controller states (IDLE, RUN, FIN)
//   - nchunk_f  : number of CHUNK-wide slices in a WIDTH-bit operand
//   - idx_w_f   : chunk index width, never narrower than one bit
package multicycle_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  function automatic int nchunk_f(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int idx_w_f(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/multicycle_adder_chunk.sv
// adder_chunk
//   Combinational W-bit slice of the multi-cycle adder.
//   Ports:
//     a_i, b_i     : slice operands (b_i already inverted for subtract)
//     cin_i        : carry into bit 0 of the slice
//     s_o          : slice sum
//     cout_o       : carry out of the slice MSB
//     c_msb_in_o   : carry into the slice MSB, used for signed overflow
module adder_chunk
  import multicycle_adder_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic         cout_o,
  output logic         c_msb_in_o
);

  logic [W:0] full;

  assign full       = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
  assign s_o        = full[W-1:0];
  assign cout_o     = full[W];
  // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c.
  assign c_msb_in_o = full[W-1] ^ a_i[W-1] ^ b_i[W-1];

endmodule

// File: rtl/multicycle_adder.sv
// multicycle_adder
//   Add/subtract unit processing CHUNK bits per clock with a registered
//   carry, so WIDTH-bit operands never see a full-width carry chain.
//   Ports:
//     clk_i, rst_n_i : clock, asynchronous active-low reset
//     start_i        : request, accepted when busy_o is low
//     sub_i          : 0 = a + b + cin, 1 = a - b (cin ignored)
//     a_i, b_i, cin_i: operands, sampled on accept
//     busy_o         : operation in flight
//     done_o         : one-cycle pulse, result outputs just updated
//     sum_o          : last completed result
//     cout_o         : carry out of MSB (subtract: 1 = no borrow)
//     ovf_o          : two's-complement overflow
//
//   state | meaning
//   IDLE  | waiting for start_i
//   RUN   | adding chunk idx_q with the registered carry
//   FIN   | done_o high for one cycle; start_i here is accepted back-to-back
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int NCHUNK = nchunk_f(WIDTH, CHUNK);
  localparam int IDXW   = idx_w_f(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("multicycle_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_e            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              carry_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  shadow_q;
  logic [WIDTH-1:0]  shadow_d;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              ovf_q;
  logic              busy_q;
  logic              done_q;

  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic [CHUNK-1:0]  s_chunk;
  logic              c_out;
  logic              c_msb;

  // Operand slice selection by chunk index.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  adder_chunk #(
    .W(CHUNK)
  ) u_chunk (
    .a_i        (a_chunk),
    .b_i        (b_chunk),
    .cin_i      (carry_q),
    .s_o        (s_chunk),
    .cout_o     (c_out),
    .c_msb_in_o (c_msb)
  );

  // Shadow with the current slice merged in; on the last chunk this is the
  // complete result and is published directly.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        shadow_d[i*CHUNK +: CHUNK] = s_chunk;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      shadow_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, FIN: begin
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= sub_i ? ~b_i : b_i;
            carry_q <= sub_i ? 1'b1 : cin_i;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          carry_q  <= c_out;
          shadow_q <= shadow_d;
          if (idx_q == LAST_IDX) begin
            sum_q   <= shadow_d;
            cout_q  <= c_out;
            ovf_q   <= c_msb ^ c_out;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule
